// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the write-port arbiter and its neighbours: the pipeline
// write-back stage, the long-latency unit, decode and the register file.
// The slave modport is the arbiter's view of these signals. The master
// modport is the surrounding logic's view.
interface regfile_wb_arbiter_if;
    // pipeline write-back
    logic        wb_we;
    logic [4:0]  wb_wn;
    logic [31:0] wb_d;
    // long-latency result stream
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wn;
    logic [31:0] lu_d;
    // decode side
    logic        iss_valid;
    logic [4:0]  iss_wn;
    logic [4:0]  id_rna;
    logic [4:0]  id_rnb;
    logic        id_we;
    logic [4:0]  id_wn;
    logic        rd_stall;
    logic        wb_stall;
    // register-file write port and status
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
    logic        err;
    logic [31:0] pend;

    modport slave (
        input  wb_we, wb_wn, wb_d,
        input  lu_valid, lu_wn, lu_d,
        output lu_ready,
        input  iss_valid, iss_wn, id_rna, id_rnb, id_we, id_wn,
        output rd_stall, wb_stall,
        output rf_we, rf_wn, rf_d, err, pend
    );

    modport master (
        output wb_we, wb_wn, wb_d,
        output lu_valid, lu_wn, lu_d,
        input  lu_ready,
        output iss_valid, iss_wn, id_rna, id_rnb, id_we, id_wn,
        input  rd_stall, wb_stall,
        input  rf_we, rf_wn, rf_d, err, pend
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the in-order pipeline
// write-back and a long-latency unit. Long-latency results are buffered in a
// 2-entry FIFO and drain whenever the pipeline leaves the port idle. A
// scoreboard of outstanding long-latency destinations drives the decode
// stall. A starvation counter asks the pipeline to freeze when buffered
// results have been blocked for too long.
module regfile_wb_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic clrn,
    regfile_wb_arbiter_if.slave bus
);

    // FIFO storage and control
    logic [4:0]  r_fwn [2];
    logic [31:0] r_fd  [2];
    logic        r_wptr;
    logic        r_rptr;
    logic [1:0]  r_cnt;

    // write port, scoreboard, starvation, status
    logic        r_rf_we;
    logic [4:0]  r_rf_wn;
    logic [31:0] r_rf_d;
    logic        r_src_lu;
    logic [31:0] r_pend;
    logic [2:0]  r_starve;
    logic        r_wb_stall;
    logic        r_err;

    logic        w_wbx;
    logic        w_lu_ready;
    logic        w_push;
    logic        w_pop;
    logic [4:0]  w_head_wn;
    logic [31:0] w_head_d;
    logic [1:0]  w_cnt_nxt;
    logic        w_rd_stall;
    logic        w_iss_set;
    logic        w_lu_clr;
    logic [31:0] w_pend_nxt;
    logic [2:0]  w_starve_nxt;
    logic        w_wb_stall_nxt;
    logic        w_err_nxt;

    // A write to r0 is a no-op and never takes the port.
    assign w_wbx      = bus.wb_we && (bus.wb_wn != 5'd0);
    // Low while reset is held so the producer never pushes into a clearing FIFO.
    assign w_lu_ready = !clrn && (r_cnt != 2'd2);
    assign w_push     = bus.lu_valid && w_lu_ready;
    // The pipeline always wins. The FIFO head drains only on idle port cycles.
    assign w_pop      = !w_wbx && (r_cnt != 2'd0);
    assign w_head_wn  = r_fwn[r_rptr];
    assign w_head_d   = r_fd[r_rptr];

    // pend[0] is never set, so reads of index 0 return 0 without special-casing.
    assign w_rd_stall = r_pend[bus.id_rna] | r_pend[bus.id_rnb]
                      | (bus.id_we & r_pend[bus.id_wn])
                      | (bus.iss_valid & r_pend[bus.iss_wn]);

    assign w_iss_set  = bus.iss_valid && !w_rd_stall && (bus.iss_wn != 5'd0);
    // The register file captures a long-latency result on this edge.
    assign w_lu_clr   = r_rf_we && r_src_lu;

    // Next FIFO occupancy
    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 2'd1;
            2'b01:   w_cnt_nxt = r_cnt - 2'd1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Scoreboard update: clear first, so a same-register set takes priority.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_lu_clr)
            w_pend_nxt[r_rf_wn] = 1'b0;
        if (w_iss_set)
            w_pend_nxt[bus.iss_wn] = 1'b1;
        w_pend_nxt[0] = 1'b0;
    end

    // Starvation count and freeze request
    always_comb begin
        w_starve_nxt = r_starve;
        if (r_cnt == 2'd0 || w_pop)
            w_starve_nxt = 3'd0;
        else if (w_wbx && r_starve != 3'd7)
            w_starve_nxt = r_starve + 3'd1;

        w_wb_stall_nxt = r_wb_stall;
        if (w_cnt_nxt == 2'd0)
            w_wb_stall_nxt = 1'b0;
        else if (w_starve_nxt == 3'(STARVE_MAX))
            w_wb_stall_nxt = 1'b1;
    end

    // Sticky protocol error: the pipeline ignored a freeze, wrote a register
    // that is still owed a long-latency result, or the producer ignored lu_ready.
    assign w_err_nxt = r_err
                     | (w_wbx & r_wb_stall)
                     | (w_wbx & r_pend[bus.wb_wn])
                     | (bus.lu_valid & !w_lu_ready);

    // FIFO payload storage. No reset is needed because r_cnt gates all reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fwn[r_wptr] <= bus.lu_wn;
            r_fd[r_wptr]  <= bus.lu_d;
        end
    end

    // FIFO pointers and count
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
        end else begin
            if (w_push)
                r_wptr <= ~r_wptr;
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Registered write port. An r0 long-latency entry pops but writes nothing.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_rf_we  <= 1'b0;
            r_rf_wn  <= 5'd0;
            r_rf_d   <= 32'd0;
            r_src_lu <= 1'b0;
        end else if (w_wbx) begin
            r_rf_we  <= 1'b1;
            r_rf_wn  <= bus.wb_wn;
            r_rf_d   <= bus.wb_d;
            r_src_lu <= 1'b0;
        end else if (w_pop && w_head_wn != 5'd0) begin
            r_rf_we  <= 1'b1;
            r_rf_wn  <= w_head_wn;
            r_rf_d   <= w_head_d;
            r_src_lu <= 1'b1;
        end else begin
            r_rf_we  <= 1'b0;
            r_src_lu <= 1'b0;
        end
    end

    // Scoreboard, starvation and status registers
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_pend     <= 32'd0;
            r_starve   <= 3'd0;
            r_wb_stall <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pend     <= w_pend_nxt;
            r_starve   <= w_starve_nxt;
            r_wb_stall <= w_wb_stall_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign bus.lu_ready = w_lu_ready;
    assign bus.rd_stall = w_rd_stall;
    assign bus.wb_stall = r_wb_stall;
    assign bus.rf_we    = r_rf_we;
    assign bus.rf_wn    = r_rf_wn;
    assign bus.rf_d     = r_rf_d;
    assign bus.err      = r_err;
    assign bus.pend     = r_pend;

endmodule
